if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the pipelined core. It owns the PC register and drives the instruction-memory request/ack handshake. It also owns the IF/ID pipeline register. Each cycle it supplies the current `pc` to the next-PC logic and loads the `npc` it receives back. EX-stage redirects (`jump != 0`) flush the IF/ID register, and stale fetches still in flight are dropped.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INST`, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush/empty

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `npc`  in  32  next PC from next-PC logic (equals pc+4 when `jump==0`)
- `jump`  in  2  redirect code from EX: 0 none, 1 branch, 2 jalr; nonzero = redirect
- `stall`  in  1  hazard unit: ID cannot accept; hold PC and IF/ID
- `pc`  out  32  current fetch PC (to next-PC logic)
- `imem_req`  out  1  fetch request, held high until `imem_ack`
- `imem_addr`  out  32  fetch address, stable while `imem_req` high
- `imem_ack`  in  1  memory returns data this cycle (may be same cycle as req)
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_pc`  out  32  PC of IF/ID instruction
- `id_pc4`  out  32  `id_pc + 4`
- `id_inst`  out  32  IF/ID instruction

## Operation
- States: FETCH (request outstanding at `pc`), HOLD (instruction received, ID stalled, stored in hold buffer), DISCARD (redirect taken while a request is outstanding; next ack is stale).
- `imem_req` = 1 in FETCH and DISCARD, 0 in HOLD and while `rst` high. `imem_addr` = `pc` in FETCH/HOLD; old `pc` in DISCARD until that request is acked.
- Priority each cycle: `jump != 0` > `stall` > normal advance.
- FETCH, `jump!=0`:
  - with `imem_ack`: drop data, `pc<=npc`, stay FETCH.
  - without `imem_ack`: `redir_pc<=npc`, go DISCARD (address must not change mid-request).
- FETCH, ack, no jump, `!stall`: IF/ID <= {1, pc, pc+4, imem_rdata}, `pc<=npc`, stay FETCH.
- FETCH, ack, no jump, `stall`: hold buffer <= {pc, imem_rdata}, IF/ID unchanged, go HOLD.
- FETCH, no ack, no jump: `pc` unchanged. If `!stall`, IF/ID <= bubble; else IF/ID holds.
- HOLD, `jump!=0`: drop buffer, `pc<=npc`, go FETCH.
- HOLD, `!stall`: IF/ID <= {1, buffered pc, pc+4, buffered inst}, `pc<=npc`, go FETCH. If `stall`, remain in HOLD.
- DISCARD, on ack: data dropped, `pc<=redir_pc`, go FETCH. A further `jump!=0` while in DISCARD overwrites `redir_pc` with the newer `npc` (the later target wins).
- Flush: any cycle with `jump!=0` loads IF/ID with bubble (`id_valid=0`, `id_inst=NOP_INST`), even when `stall` is high.
- Bubble: `id_valid=0`, `id_inst=NOP_INST`; `id_pc` and `id_pc4` keep their prior values.
- Arithmetic: 32-bit, `pc+4` wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No alignment check.

## Timing
- Reset values: `pc=RESET_PC`, state FETCH, `id_valid=0`, `id_pc=0`, `id_pc4=0`, `id_inst=NOP_INST`, `redir_pc=0`, hold buffer 0.
- Reset mid-request: the outstanding request is abandoned and the first fetch after deassert is at `RESET_PC`.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. The instruction appears on `id_*` in the cycle after ack.
- N wait states: N bubble cycles in ID per instruction.
- Redirect cost: the IF/ID flush is visible the cycle after `jump`. The first fetch at the target starts the cycle after `jump`, or the cycle after the stale ack when in DISCARD.
- Stall release from HOLD: the buffered instruction reaches ID one cycle after `stall` falls; the new request is issued that same cycle.

## Test plan
- Reset, zero-wait memory returning `addr`-derived words, `RESET_PC=0`: `id_pc` runs 0,4,8,… one per cycle; `id_valid=1` from cycle 2 after reset release.
- Stall for 3 cycles after ack at PC 0x8: IF/ID holds PC 0x4, state HOLD, `imem_req=0`. After release, `id_pc=0x8` once, then 0xC follows.
- Redirect `jump=1`, `npc=0x100` while at PC 0x10 with no wait states: next `id_valid=0`, `id_inst=0x13`; the next fetch address is 0x100.
- Two-wait-state memory, `jump=2`, `npc=0x200` in the first wait cycle: `imem_addr` stays at the old PC until ack; that data is dropped; the next request is to 0x200 and the old word never reaches ID.
- Simultaneous `stall=1` and `jump=1`: flush wins; IF/ID becomes a bubble and the PC loads `npc`.
- `RESET_PC=32'hFFFF_FFFC`: first `id_pc4=0`; next fetch address is 0x0.
- Assert `rst` while in DISCARD: all outputs return to reset values asynchronously; the fetch after release is at `RESET_PC`.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request/ack handshake and IF/ID register.
// state   | meaning
// FETCH   | request outstanding at pc
// HOLD    | word received while ID stalled, parked in hold buffer, no request
// DISCARD | redirect arrived mid-request; next ack is stale, then fetch redir_pc
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic [1:0]  jump,
  input  logic        stall,
  output logic [31:0] pc,
  if_stage_if.master  imem,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic [31:0] redir_pc, redir_nx;
  logic [31:0] hold_pc, hold_pc_nx;
  logic [31:0] hold_inst, hold_inst_nx;
  logic        id_load, id_flush;
  logic [31:0] id_load_pc, id_load_inst;
  logic        redirect;

  assign redirect = (jump != 2'b00);

  // Address comes straight from pc: pc is frozen in DISCARD, so the old
  // request address stays stable until the stale ack.
  assign imem.imem_req  = !rst && (state != HOLD);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      redir_pc  <= 32'h0;
      hold_pc   <= 32'h0;
      hold_inst <= 32'h0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      redir_pc  <= redir_nx;
      hold_pc   <= hold_pc_nx;
      hold_inst <= hold_inst_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    redir_nx     = redir_pc;
    hold_pc_nx   = hold_pc;
    hold_inst_nx = hold_inst;
    id_load      = 1'b0;
    id_flush     = 1'b0;
    id_load_pc   = pc;
    id_load_inst = imem.imem_rdata;
    case (state)
      FETCH: begin
        if (redirect) begin
          id_flush = 1'b1;
          if (imem.imem_ack) begin
            pc_nx = npc;
          end else begin
            redir_nx = npc;
            state_nx = DISCARD;
          end
        end else if (imem.imem_ack) begin
          if (stall) begin
            hold_pc_nx   = pc;
            hold_inst_nx = imem.imem_rdata;
            state_nx     = HOLD;
          end else begin
            id_load = 1'b1;
            pc_nx   = npc;
          end
        end else if (!stall) begin
          id_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          id_flush = 1'b1;
          pc_nx    = npc;
          state_nx = FETCH;
        end else if (!stall) begin
          id_load      = 1'b1;
          id_load_pc   = hold_pc;
          id_load_inst = hold_inst;
          pc_nx        = npc;
          state_nx     = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          id_flush = 1'b1;
          redir_nx = npc;
        end else if (!stall) begin
          id_flush = 1'b1;
        end
        // A redirect landing on the stale ack itself is the newest target.
        if (imem.imem_ack) begin
          pc_nx    = redirect ? npc : redir_pc;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_pc4   <= 32'h0;
      id_inst  <= NOP_INST;
    end else if (id_flush) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (id_load) begin
      id_valid <= 1'b1;
      id_pc    <= id_load_pc;
      id_pc4   <= id_load_pc + 32'd4;
      id_inst  <= id_load_inst;
    end
  end

endmodule
